// File: rtl/md_ctrl_pkg.sv
// Shared encodings for the multiply/divide controller: md_op codes,
// FSM states and the {hi,lo} result bundle.
package md_ctrl_pkg;

  typedef enum logic [3:0] {
    MD_NOP   = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

  localparam int CNT_W = 8;

endpackage

// File: rtl/md_ctrl_calc.sv
// Combinational 64-bit product and quotient/remainder for MULT(U)/DIV(U),
// including divide-by-zero and signed-overflow results.
module md_ctrl_calc
  import md_ctrl_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output md_res_t     o_res
);

  logic        w_sgn;
  logic        w_mul;
  logic        w_div;
  logic [63:0] w_a64;
  logic [63:0] w_b64;
  logic [63:0] w_prod;
  logic [31:0] w_ma;
  logic [31:0] w_mb;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_q;
  logic [31:0] w_r;

  assign w_sgn = (i_op == MD_MULT) || (i_op == MD_DIV);
  assign w_mul = (i_op == MD_MULT) || (i_op == MD_MULTU);
  assign w_div = (i_op == MD_DIV) || (i_op == MD_DIVU);

  assign w_a64  = {{32{w_sgn & i_a[31]}}, i_a};
  assign w_b64  = {{32{w_sgn & i_b[31]}}, i_b};
  assign w_prod = w_a64 * w_b64;

  // Sign-magnitude divide: 0x8000_0000 / -1 lands on 0x8000_0000, rem 0
  assign w_ma = (w_sgn & i_a[31]) ? -i_a : i_a;
  assign w_mb = (w_sgn & i_b[31]) ? -i_b : i_b;
  assign w_uq = (w_mb == '0) ? '0 : w_ma / w_mb;
  assign w_ur = (w_mb == '0) ? '0 : w_ma % w_mb;
  assign w_q  = (w_sgn & (i_a[31] ^ i_b[31])) ? -w_uq : w_uq;
  assign w_r  = (w_sgn & i_a[31]) ? -w_ur : w_ur;

  always_comb begin
    o_res = '0;
    unique case (1'b1)
      w_mul: o_res = w_prod;
      w_div: begin
        if (i_b == '0) begin
          o_res.hi = i_a;
          o_res.lo = 32'hFFFF_FFFF;
        end else begin
          o_res.hi = w_r;
          o_res.lo = w_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// Multi-cycle MD controller: FSM, busy counter and HI/LO registers.
// Optional MD_DIV0_HOLD_EN: divide by zero leaves HI/LO unchanged.
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [3:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  md_state_e        r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [31:0]      r_hi, w_hi;
  logic [31:0]      r_lo, w_lo;
  md_res_t          r_tmp, w_tmp;
  md_res_t          w_res;
  logic             w_is_mul;
  logic             w_is_div;
  logic             w_div0_hold;

  md_ctrl_calc u_calc (
    .i_op  (md_op),
    .i_a   (md_a),
    .i_b   (md_b),
    .o_res (w_res)
  );

  assign w_is_mul = (md_op == MD_MULT) || (md_op == MD_MULTU);
  assign w_is_div = (md_op == MD_DIV) || (md_op == MD_DIVU);

`ifdef MD_DIV0_HOLD_EN
  assign w_div0_hold = (md_b == '0);
`else
  assign w_div0_hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_tmp   <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_hi    <= w_hi;
      r_lo    <= w_lo;
      r_tmp   <= w_tmp;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_hi    = r_hi;
    w_lo    = r_lo;
    w_tmp   = r_tmp;
    unique case (r_state)
      ST_IDLE: begin
        if (md_start) begin
          unique case (1'b1)
            w_is_mul: begin
              w_state = ST_MUL;
              w_cnt   = CNT_W'(MULT_CYCLES);
              w_tmp   = w_res;
            end
            w_is_div: begin
              w_state = ST_DIV;
              w_cnt   = CNT_W'(DIV_CYCLES);
              // held divide commits the current HI/LO back unchanged
              w_tmp   = w_div0_hold ? {r_hi, r_lo} : w_res;
            end
            (md_op == MD_MTHI): w_hi = md_a;
            (md_op == MD_MTLO): w_lo = md_a;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state = ST_IDLE;
          w_cnt   = '0;
          w_hi    = r_tmp.hi;
          w_lo    = r_tmp.lo;
        end else begin
          w_cnt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  assign busy = (r_state != ST_IDLE);
  assign hi   = r_hi;
  assign lo   = r_lo;

  always_comb begin
    md_out = '0;
    if (md_op == MD_MFHI) md_out = r_hi;
    else if (md_op == MD_MFLO) md_out = r_lo;
  end

endmodule

// File: tb/tb_md_ctrl.sv
// Bench for md_ctrl: directed cases from the spec plus random traffic,
// checked every cycle against a time-based behavioural model.
module tb_md_ctrl;
  import md_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        md_start = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] md_a = '0;
  logic [31:0] md_b = '0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  always #5 clk = ~clk;

  md_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .md_start (md_start),
    .md_op    (md_op),
    .md_a     (md_a),
    .md_b     (md_b),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo),
    .md_out   (md_out)
  );

  int errors = 0;
  int checks = 0;
  int ignored = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: pending result commits at a fixed edge index, not via a countdown
  bit          m_valid = 0;
  bit          m_pending = 0;
  bit          p_keep = 0;
  int          cyc = 0;
  int          m_commit = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] p_hi = '0;
  logic [31:0] p_lo = '0;

  function automatic void compute(input logic [3:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] rh,
                                  output logic [31:0] rl,
                                  output bit keep);
    longint sa, sb, sp, q, r;
    longint unsigned ua, ub, up;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    keep = 0;
    rh = '0;
    rl = '0;
    if (op == MD_MULT) begin
      sp = sa * sb;
      rh = sp[63:32];
      rl = sp[31:0];
    end else if (op == MD_MULTU) begin
      up = ua * ub;
      rh = up[63:32];
      rl = up[31:0];
    end else if (b == 0) begin
`ifdef MD_DIV0_HOLD_EN
      keep = 1;
`else
      rh = a;
      rl = 32'hFFFF_FFFF;
`endif
    end else if (op == MD_DIV) begin
      q = sa / sb;
      r = sa % sb;
      rh = r[31:0];
      rl = q[31:0];
    end else begin
      rh = a % b;
      rl = a / b;
    end
  endfunction

  always @(posedge clk) begin
    cyc++;
    m_valid = 1;
    if (reset) begin
      m_hi = '0;
      m_lo = '0;
      m_pending = 0;
    end else if (m_pending) begin
      if (md_start) ignored++;
      if (cyc == m_commit) begin
        if (!p_keep) begin
          m_hi = p_hi;
          m_lo = p_lo;
        end
        m_pending = 0;
      end
    end else if (md_start) begin
      case (md_op)
        MD_MULT, MD_MULTU: begin
          compute(md_op, md_a, md_b, p_hi, p_lo, p_keep);
          m_pending = 1;
          m_commit = cyc + 5;
        end
        MD_DIV, MD_DIVU: begin
          compute(md_op, md_a, md_b, p_hi, p_lo, p_keep);
          m_pending = 1;
          m_commit = cyc + 10;
        end
        MD_MTHI: m_hi = md_a;
        MD_MTLO: m_lo = md_a;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [31:0] exp_out;
    if (m_valid) begin
      exp_out = (md_op == MD_MFHI) ? m_hi :
                (md_op == MD_MFLO) ? m_lo : 32'h0;
      check("busy", {31'b0, busy}, {31'b0, m_pending});
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      check("md_out", md_out, exp_out);
    end
  end

  task automatic issue(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    md_start = 1'b1;
    md_op = op;
    md_a = a;
    md_b = b;
    @(posedge clk);
    #1;
    md_start = 1'b0;
    md_op = MD_NOP;
  endtask

  task automatic wait_idle(string name, int exp);
    int k = 0;
    while (busy !== 1'b0 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, k, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst busy", {31'b0, busy}, 32'h0);
    check("rst hi", hi, 32'h0);
    check("rst lo", lo, 32'h0);

    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_idle("mult lat", 5);
    check("mult hi", hi, 32'hFFFF_FFFF);
    check("mult lo", lo, 32'hFFFF_FFFA);

    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_idle("multu lat", 5);
    check("multu hi", hi, 32'h1);
    check("multu lo", lo, 32'hFFFF_FFFE);

    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div lat", 10);
    check("div hi", hi, 32'hFFFF_FFFF);
    check("div lo", lo, 32'hFFFF_FFFD);

    issue(MD_MTHI, 32'h11, 32'h0);
    wait_idle("mthi lat", 0);
    issue(MD_MTLO, 32'h22, 32'h0);
    issue(MD_DIV, 32'd5, 32'd0);
    wait_idle("div0 lat", 10);
`ifdef MD_DIV0_HOLD_EN
    check("div0 hi", hi, 32'h11);
    check("div0 lo", lo, 32'h22);
`else
    check("div0 hi", hi, 32'h5);
    check("div0 lo", lo, 32'hFFFF_FFFF);
`endif

    issue(MD_MTLO, 32'h1234, 32'h0);
    check("mtlo busy", {31'b0, busy}, 32'h0);
    check("mtlo lo", lo, 32'h1234);
    md_op = MD_MFLO;
    #1;
    check("mflo out", md_out, 32'h1234);
    md_op = MD_NOP;

    issue(MD_MULT, 32'd7, 32'd9);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort busy", {31'b0, busy}, 32'h0);
    check("abort hi", hi, 32'h0);
    check("abort lo", lo, 32'h0);
    repeat (8) @(posedge clk);
    #1;
    check("no commit lo", lo, 32'h0);

    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(MD_MTHI, 32'hAA, 32'h0);
    wait_idle("ovf lat", 9);
    check("ovf hi", hi, 32'h0);
    check("ovf lo", lo, 32'h8000_0000);

    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 99) < 2);
      md_start = ($urandom_range(0, 2) != 0);
      md_op = 4'($urandom_range(0, 10));
      md_a = pick();
      md_b = pick();
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    md_start = 1'b0;
    md_op = MD_NOP;
    repeat (12) @(posedge clk);
    #1;

    $display("note: %0d starts issued while busy were ignored", ignored);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
